mux_n_to_1_arb: RTL and testbench

Parametrised successor to the generic N-to-1 mux. It accepts N valid/ready input streams of M-bit data and picks one per cycle, either by an external select or by round-robin arbitration. The chosen beat is registered into a one-entry output stage with a valid/ready handshake. It sits between several producers and a single shared consumer, for example a bus or a UART transmit path.

---
 rtl/mux_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 73 +++++++
 rtl/mux_n_to_1_arb.sv | 131 +++++++++++++
 tb/tb_mux_n_to_1_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and helpers for the N-to-1 arbitrated mux.
//   mux_mode_e : MUX_FIXED (external select) or MUX_RR (round-robin)
//   rr_pick    : one-hot round-robin pick, searching upward from ptr with wrap
package mux_arb_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  // Widest request vector rr_pick handles; callers size-cast to and from N.
  localparam int RR_MAX_N = 64;
  localparam int RR_IDX_W = $clog2(RR_MAX_N);

  // Returns a one-hot vector with the first set req bit at or after ptr,
  // wrapping modulo n; all zero when no request is set.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input int ptr,
                                                  input int n);
    logic [RR_MAX_N-1:0] grant;
    logic                found;
    int                  j;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !found && req[j[RR_IDX_W-1:0]]) begin
        grant[j[RR_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant generator with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request (input valid)
//   advance    : a beat was accepted this cycle from channel adv_idx
//   adv_idx    : index of the accepted channel
//   adv_last   : accepted beat ends its packet (only with MUX_ARB_LOCK_EN)
//   grant      : combinational one-hot (or zero) grant
//   ptr        : current round-robin pointer
// Build option: MUX_ARB_LOCK_EN holds the grant on one channel until the
// beat flagged last, and advances the pointer only on that beat.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [SEL_W-1:0] adv_idx,
`ifdef MUX_ARB_LOCK_EN
  input  logic             adv_last,
`endif
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] ptr
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] next_ptr;

  assign next_ptr = (int'(adv_idx) == N - 1) ? '0 : adv_idx + SEL_W'(1);
  assign ptr      = ptr_q;

`ifdef MUX_ARB_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_idx_q;

  // While locked only the owning channel can win, even if it is momentarily
  // idle; other channels wait for the packet to finish.
  always_comb begin
    grant = N'(rr_pick(RR_MAX_N'(req), int'(ptr_q), N));
    if (lock_q) begin
      grant             = '0;
      grant[lock_idx_q] = req[lock_idx_q];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (advance) begin
      lock_q     <= ~adv_last;
      lock_idx_q <= adv_idx;
      if (adv_last) ptr_q <= next_ptr;
    end
  end
`else
  assign grant = N'(rr_pick(RR_MAX_N'(req), int'(ptr_q), N));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= '0;
    else if (advance) ptr_q <= next_ptr;
  end
`endif

endmodule

// File: rtl/mux_n_to_1_arb.sv
// mux_n_to_1_arb: N valid/ready input streams of M-bit data merged into one
// registered output stage. Channel choice is an external select (MUX_FIXED)
// or round-robin (MUX_RR). Full throughput: the output register can drain
// and refill in the same cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : low blocks new input beats; the output still drains
//   select       : channel choice in MUX_FIXED mode (>= N grants nothing)
//   in_valid     : per-channel beat valid
//   in_data      : per-channel data, in_data[i] belongs to channel i
//   in_ready     : per-channel accept, at most one bit high
//   out_valid    : output register holds a beat
//   out_data     : registered data
//   out_sel      : channel that produced out_data
//   out_ready    : consumer accepts the beat
// Build option MUX_ARB_LOCK_EN adds in_last/out_last and packet lock: after
// a non-last beat from channel g the grant stays on g until its last beat.
module mux_n_to_1_arb
  import mux_arb_pkg::*;
#(
  parameter int        N     = 4,
  parameter int        M     = 8,
  parameter mux_mode_e MODE  = MUX_RR,
  parameter int        SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [SEL_W-1:0] select,
  input  logic [N-1:0]     in_valid,
  input  logic [M-1:0]     in_data [N],
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [M-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] g_idx;
  logic             can_load;
  logic             load;

  // rst_n gates in_ready so no producer sees an accept while in reset.
  assign can_load = ~out_valid | out_ready;
  assign in_ready = grant & {N{enable & can_load & rst_n}};
  assign load     = |(in_valid & in_ready);

  // NOTE: combinational outputs get a default before any conditional
  // assignment so no path leaves them unassigned (which would infer a latch).
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) g_idx = SEL_W'(i);
    end
  end

  if (MODE == MUX_RR) begin : g_rr
    logic [SEL_W-1:0] ptr_unused;
    logic             select_unused;

    // select has no meaning in round-robin mode; the pointer is only for debug.
    assign select_unused = ^select;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .advance (load),
      .adv_idx (g_idx),
`ifdef MUX_ARB_LOCK_EN
      .adv_last(in_last[g_idx]),
`endif
      .grant   (grant),
      .ptr     (ptr_unused)
    );
  end else begin : g_fixed
    logic [SEL_W-1:0] sel_eff;

`ifdef MUX_ARB_LOCK_EN
    logic             lock_q;
    logic [SEL_W-1:0] lock_idx_q;

    // An open packet overrides the external select.
    assign sel_eff = lock_q ? lock_idx_q : select;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else if (load) begin
        lock_q     <= ~in_last[g_idx];
        lock_idx_q <= g_idx;
      end
    end
`else
    assign sel_eff = select;
`endif

    always_comb begin
      grant = '0;
      if (int'(sel_eff) < N) grant[sel_eff] = in_valid[sel_eff];
    end
  end

  // NOTE: the data/sel registers are reset too because their post-reset
  // value is architecturally visible, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[g_idx];
      out_sel   <= g_idx;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= in_last[g_idx];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// tb_mux_n_to_1_arb: self-checking bench for mux_n_to_1_arb.
// Three instances share clk/rst_n: u_rr (MUX_RR, N=4), u_fx (MUX_FIXED, N=4)
// and u_fx6 (MUX_FIXED, N=6). Inputs change and outputs are sampled on the
// falling edge; in_ready is sampled 1 ns after inputs change.
module tb_mux_n_to_1_arb;
  import mux_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   a_step = 0;

  // Round-robin instance
  logic       a_enable;
  logic [1:0] a_select;
  logic [3:0] a_in_valid;
  logic [7:0] a_in_data [4];
  logic [3:0] a_in_ready;
  logic       a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_out_sel;
  logic       a_out_ready;
  // Fixed instance, N=4
  logic       b_enable;
  logic [1:0] b_select;
  logic [3:0] b_in_valid;
  logic [7:0] b_in_data [4];
  logic [3:0] b_in_ready;
  logic       b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_out_sel;
  logic       b_out_ready;
  // Fixed instance, N=6
  logic       c_enable;
  logic [2:0] c_select;
  logic [5:0] c_in_valid;
  logic [7:0] c_in_data [6];
  logic [5:0] c_in_ready;
  logic       c_out_valid;
  logic [7:0] c_out_data;
  logic [2:0] c_out_sel;
  logic       c_out_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [3:0] a_in_last;
  logic       a_out_last;
  logic [3:0] b_in_last;
  logic       b_out_last;
  logic [5:0] c_in_last;
  logic       c_out_last;
`endif

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic       en;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } a_vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } b_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       last;
  } sb_item_t;

  localparam int A_N = 19;
  localparam int B_N = 8;
  localparam int L_N = 8;
  a_vec_t   a_tab [A_N];
  b_vec_t   b_tab [B_N];
  a_vec_t   l_tab [L_N];
  sb_item_t sb_q [$];

  mux_n_to_1_arb #(.N(4), .M(8), .MODE(MUX_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .select(a_select),
    .in_valid(a_in_valid), .in_data(a_in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last(a_in_last), .out_last(a_out_last),
`endif
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_ready(a_out_ready)
  );

  mux_n_to_1_arb #(.N(4), .M(8), .MODE(MUX_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .select(b_select),
    .in_valid(b_in_valid), .in_data(b_in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last(b_in_last), .out_last(b_out_last),
`endif
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready)
  );

  mux_n_to_1_arb #(.N(6), .M(8), .MODE(MUX_FIXED)) u_fx6 (
    .clk(clk), .rst_n(rst_n), .enable(c_enable), .select(c_select),
    .in_valid(c_in_valid), .in_data(c_in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last(c_in_last), .out_last(c_out_last),
`endif
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_ready(c_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle on the round-robin instance: drive at the falling edge, check
  // in_ready, pop the scoreboard for a beat leaving the output, push the beat
  // the vector says is accepted, then check the registered state.
  task automatic run_a(input a_vec_t v);
    sb_item_t it;
    a_step++;
    a_in_valid  = v.valid;
    a_out_ready = v.ordy;
    a_enable    = v.en;
`ifdef MUX_ARB_LOCK_EN
    a_in_last   = v.last;
`endif
    for (int i = 0; i < 4; i++) a_in_data[i] = 8'(a_step * 16 + i * 3 + 1);
    #1;
    check("a_in_ready", 32'(a_in_ready), 32'(v.exp_rdy));
    if (a_out_valid && v.ordy) begin
      check("a_sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        check("a_sb_data", 32'(a_out_data), 32'(it.data));
        check("a_sb_sel", 32'(a_out_sel), 32'(it.sel));
`ifdef MUX_ARB_LOCK_EN
        check("a_sb_last", 32'(a_out_last), 32'(it.last));
`endif
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (v.exp_rdy[i] && v.valid[i])
        sb_q.push_back('{data: a_in_data[i], sel: 2'(i), last: v.last[i]});
    end
    @(posedge clk);
    @(negedge clk);
    check("a_out_valid", 32'(a_out_valid), 32'(v.exp_ov));
    check("a_out_sel", 32'(a_out_sel), 32'(v.exp_sel));
  endtask

  task automatic run_b(input b_vec_t v);
    b_select    = v.sel;
    b_in_valid  = v.valid;
    b_out_ready = v.ordy;
    #1;
    check("b_in_ready", 32'(b_in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    @(negedge clk);
    check("b_out_valid", 32'(b_out_valid), 32'(v.exp_ov));
    check("b_out_sel", 32'(b_out_sel), 32'(v.exp_sel));
    check("b_out_data", 32'(b_out_data), 32'(v.exp_data));
  endtask

  initial begin
    //           valid    last     ordy  en    exp_rdy  ov    sel
    a_tab[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    a_tab[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    a_tab[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    a_tab[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
    a_tab[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    a_tab[5]  = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    a_tab[6]  = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
    a_tab[7]  = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    a_tab[8]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
    a_tab[9]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
    a_tab[10] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
    a_tab[11] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    a_tab[12] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
    a_tab[13] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    a_tab[14] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    a_tab[15] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1};
    a_tab[16] = '{4'b1001, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
    a_tab[17] = '{4'b1001, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    a_tab[18] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};

    //          sel   valid    ordy  exp_rdy  ov    sel   data
    b_tab[0] = '{2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    b_tab[1] = '{2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    b_tab[2] = '{2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    b_tab[3] = '{2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    b_tab[4] = '{2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};
    b_tab[5] = '{2'd2, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h33};
    b_tab[6] = '{2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h33};
    b_tab[7] = '{2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};

    // Packet lock: ch1 moves the pointer to 2, then ch2 sends a 3-beat packet
    // (with a bubble mid-packet) while ch0 and ch3 wait.
    l_tab[0] = '{4'b0010, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    l_tab[1] = '{4'b1101, 4'b1011, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    l_tab[2] = '{4'b1101, 4'b1011, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    l_tab[3] = '{4'b1001, 4'b1011, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2};
    l_tab[4] = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    l_tab[5] = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
    l_tab[6] = '{4'b1101, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    l_tab[7] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst_n       = 1'b0;
    a_enable    = 1'b1;
    a_select    = 2'd0;
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b1;
    b_enable    = 1'b1;
    b_select    = 2'd0;
    b_in_valid  = 4'b1111;
    b_out_ready = 1'b1;
    c_enable    = 1'b1;
    c_select    = 3'd0;
    c_in_valid  = 6'b0;
    c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data[i] = 8'h00;
      b_in_data[i] = 8'(8'h11 * (i + 1));
    end
    for (int i = 0; i < 6; i++) c_in_data[i] = 8'(8'hC0 + i);
`ifdef MUX_ARB_LOCK_EN
    a_in_last = 4'b1111;
    b_in_last = 4'b1111;
    c_in_last = 6'b111111;
`endif

    // Reset with valid inputs: outputs cleared, no accepts.
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_a_out_sel", 32'(a_out_sel), 32'd0);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    @(negedge clk);
    b_in_valid = 4'b0000;
    rst_n      = 1'b1;

    for (int s = 0; s < A_N; s++) run_a(a_tab[s]);
    for (int s = 0; s < B_N; s++) run_b(b_tab[s]);
    b_in_valid = 4'b0000;

    // Out-of-range select on the 6-channel fixed mux.
    c_in_valid = 6'b111111;
    c_select   = 3'd7;
    #1;
    check("c_sel7_in_ready", 32'(c_in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("c_sel7_out_valid", 32'(c_out_valid), 32'd0);
    c_select = 3'd5;
    #1;
    check("c_sel5_in_ready", 32'(c_in_ready), 32'b100000);
    @(posedge clk);
    @(negedge clk);
    check("c_sel5_out_valid", 32'(c_out_valid), 32'd1);
    check("c_sel5_out_sel", 32'(c_out_sel), 32'd5);
    check("c_sel5_out_data", 32'(c_out_data), 32'hC5);
    c_select = 3'd7;
    #1;
    check("c_sel7b_in_ready", 32'(c_in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("c_sel7b_out_valid", 32'(c_out_valid), 32'd0);
    check("c_sel7b_out_sel", 32'(c_out_sel), 32'd5);
    c_in_valid = 6'b0;

`ifdef MUX_ARB_LOCK_EN
    for (int s = 0; s < L_N; s++) run_a(l_tab[s]);
`endif

    // Reset while a beat is held and every input is valid: the beat is lost
    // and the pointer restarts at channel 0.
    run_a('{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1});
    b_in_valid  = 4'b1111;
    b_select    = 2'd0;
    b_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_a_out_data", 32'(a_out_data), 32'd0);
    check("mid_rst_a_out_sel", 32'(a_out_sel), 32'd0);
    check("mid_rst_a_in_ready", 32'(a_in_ready), 32'd0);
    check("mid_rst_b_in_ready", 32'(b_in_ready), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n      = 1'b1;
    b_in_valid = 4'b0000;
    run_a('{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0});
    run_a('{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0});
    check("a_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
